// File: rtl/hazard_detect_unit_pkg.sv
// Shared definitions for the hazard detector and the forwarding unit:
// pipeline record layout, register width and stall FSM encodings.
package hazard_detect_unit_pkg;

    localparam int REG_W     = 5;
    localparam int REC_W     = 8;
    localparam int LCNT_W    = 3;

    localparam int REC_VALID = 0;
    localparam int REC_MEMRD = 1;
    localparam int REC_REGWR = 2;
    localparam int REC_DEST  = 3;

    localparam logic [0:0] HZ_IDLE  = 1'b0;
    localparam logic [0:0] HZ_STALL = 1'b1;

    typedef logic [REC_W-1:0] rec_t;

    localparam rec_t REC_EMPTY = '0;

    function automatic rec_t pack_rec(input logic             valid,
                                      input logic [REG_W-1:0] dest,
                                      input logic             mem_read,
                                      input logic             reg_write);
        rec_t r;
        r                     = '0;
        r[REC_VALID]          = valid;
        r[REC_MEMRD]          = mem_read;
        r[REC_REGWR]          = reg_write;
        r[REC_DEST +: REG_W]  = dest;
        return r;
    endfunction

endpackage

// File: rtl/hazard_stage_rec.sv
// One in-flight pipeline record (EX or MEM); a bubble loads an empty record.
module hazard_stage_rec
    import hazard_detect_unit_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  rec_t rec_i,
    input  logic bubble_i,
    output rec_t rec_o
);

    rec_t rec_q;
    rec_t rec_d;

    assign rec_d = bubble_i ? REC_EMPTY : rec_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rec_q <= REC_EMPTY;
        end else begin
            rec_q <= rec_d;
        end
    end

    assign rec_o = rec_q;

endmodule

// File: rtl/hazard_detect_unit.sv
// ID-stage load-use hazard detector: tracks EX/MEM destination records and
// generates PC/IF-ID write enables, the ID/EX bubble and the branch flush.
module hazard_detect_unit
    import hazard_detect_unit_pkg::*;
#(
    parameter int LOAD_LAT = 1,   // legal range 1..7
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_is_store,
    input  logic             id_mem_read,
    input  logic             id_reg_write,
    input  logic [REG_W-1:0] id_dest,
    input  logic             ex_br_taken,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             stall_active,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [LCNT_W-1:0] LAT_RELOAD = LCNT_W'(LOAD_LAT - 1);

    rec_t             id_rec;
    rec_t             ex_rec;
    rec_t             mem_rec_unused;
    logic [REG_W-1:0] ex_dest;
    logic             hazard;
    logic             stall;
    logic             stall_g;
    logic             flush_g;

    logic [0:0]        state_q,     state_d;
    logic [LCNT_W-1:0] lat_cnt_q,   lat_cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    assign id_rec  = pack_rec(id_valid, id_dest, id_mem_read, id_reg_write);
    assign ex_dest = ex_rec[REC_DEST +: REG_W];

    // A store matching only on rt is served by forwarding, so it never stalls.
    assign hazard = ex_rec[REC_VALID] && ex_rec[REC_MEMRD] && (ex_dest != '0) && id_valid &&
                    ((id_uses_rs && (id_rs == ex_dest)) ||
                     (id_uses_rt && (id_rt == ex_dest) && !id_is_store));

    always_comb begin
        state_d   = state_q;
        lat_cnt_d = lat_cnt_q;
        stall     = 1'b0;
        if (ex_br_taken) begin
            state_d   = HZ_IDLE;
            lat_cnt_d = '0;
        end else if (state_q == HZ_STALL) begin
            stall     = 1'b1;
            lat_cnt_d = lat_cnt_q - LCNT_W'(1);
            if (lat_cnt_d == '0) begin
                state_d = HZ_IDLE;
            end
        end else if (hazard) begin
            stall     = 1'b1;
            lat_cnt_d = LAT_RELOAD;
            state_d   = (LOAD_LAT > 1) ? HZ_STALL : HZ_IDLE;
        end
    end

    assign stall_cnt_d = (stall && (stall_cnt_q != '1)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= HZ_IDLE;
            lat_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            lat_cnt_q   <= lat_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Stalled or flushed cycles push an empty record into EX.
    hazard_stage_rec u_ex_rec (
        .clk      (clk),
        .rst_n    (rst_n),
        .rec_i    (id_rec),
        .bubble_i (stall | ex_br_taken),
        .rec_o    (ex_rec)
    );

    // MEM record mirrors the pipeline for the forwarding unit; not read here.
    hazard_stage_rec u_mem_rec (
        .clk      (clk),
        .rst_n    (rst_n),
        .rec_i    (ex_rec),
        .bubble_i (1'b0),
        .rec_o    (mem_rec_unused)
    );

    // Outputs fall back to their reset values while rst_n is held low.
    assign stall_g      = stall & rst_n;
    assign flush_g      = ex_br_taken & rst_n;
    assign pc_write     = ~stall_g;
    assign ifid_write   = ~stall_g;
    assign ifid_flush   = flush_g;
    assign idex_bubble  = stall_g | flush_g;
    assign stall_active = stall_g;
    assign stall_count  = stall_cnt_q;

endmodule
